// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/LS memory port arbiter: FSM states, owner ids,
// and the byte-enable pattern for instruction fetches.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_IF  = 3'd1,
        ST_REQ_LS  = 3'd2,
        ST_WAIT_IF = 3'd3,
        ST_WAIT_LS = 3'd4
    } state_e;

    localparam logic       OWNER_IF  = 1'b0;
    localparam logic       OWNER_LS  = 1'b1;
    localparam logic [3:0] IF_BE_ALL = 4'hF;

    // Request state for an arbitration winner, or IDLE when nobody asked.
    function automatic state_e req_state(input logic valid, input logic owner);
        if (!valid) return ST_IDLE;
        return (owner == OWNER_LS) ? ST_REQ_LS : ST_REQ_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb2_rr.sv
// Two-input grant logic (IF vs LS): fixed LS priority or round-robin on ties,
// remembering the last granted owner.
module arb2_rr
    import mem_port_arbiter_pkg::*;
#(
    parameter bit PRIO_LS = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req_i,
    input  logic ls_req_i,
    input  logic arb_en_i,
    output logic gnt_vld_o,
    output logic gnt_owner_o
);

    logic last_owner_q, last_owner_d;

    always_comb begin
        gnt_vld_o = if_req_i | ls_req_i;
        if (if_req_i && ls_req_i) begin
            gnt_owner_o = PRIO_LS ? OWNER_LS : ~last_owner_q;
        end else begin
            gnt_owner_o = ls_req_i ? OWNER_LS : OWNER_IF;
        end
        // Only a decision that actually starts a transaction moves the pointer.
        last_owner_d = (arb_en_i && gnt_vld_o) ? gnt_owner_o : last_owner_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_owner_q <= OWNER_IF;
        else        last_owner_q <= last_owner_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: one
// transaction at a time through REQ and WAIT, with optional response timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter bit          PRIO_LS        = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    input  logic [3:0]  ls_be_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        ls_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        owner_sel_o,
    output logic        spurious_o
);

    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             spurious_q, spurious_d;
    logic             arb_en, gnt_vld, gnt_owner;
    logic             cur_owner, timeout_hit, rsp_vld;
    logic [31:0]      rsp_data, sel_addr, sel_wdata;
    logic [3:0]       sel_be;
    logic             sel_we;

    arb2_rr #(.PRIO_LS(PRIO_LS)) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req_i   (if_req_i),
        .ls_req_i   (ls_req_i),
        .arb_en_i   (arb_en),
        .gnt_vld_o  (gnt_vld),
        .gnt_owner_o(gnt_owner)
    );

    assign cur_owner   = (state_q == ST_REQ_LS) || (state_q == ST_WAIT_LS);
    assign owner_sel_o = cur_owner;
    assign spurious_o  = spurious_q;

    // Shared datapath select; fetches are always full-word reads.
    assign sel_addr  = cur_owner ? ls_addr_i  : if_addr_i;
    assign sel_wdata = cur_owner ? ls_wdata_i : 32'h0;
    assign sel_be    = cur_owner ? ls_be_i    : IF_BE_ALL;
    assign sel_we    = cur_owner & ls_we_i;

    // A real response on the deadline cycle wins over the timeout.
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST) && !mem_rvalid_i;
    assign rsp_vld     = mem_rvalid_i | timeout_hit;
    assign rsp_data    = timeout_hit ? 32'h0 : mem_rdata_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        spurious_d  = spurious_q;
        arb_en      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        mem_be_o    = 4'h0;
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        ls_rvalid_o = 1'b0;
        if_rdata_o  = 32'h0;
        ls_rdata_o  = 32'h0;
        if_err_o    = 1'b0;
        ls_err_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arb_en  = 1'b1;
                state_d = req_state(gnt_vld, gnt_owner);
                if (mem_rvalid_i) spurious_d = 1'b1;
            end
            ST_REQ_IF, ST_REQ_LS: begin
                mem_req_o   = 1'b1;
                mem_we_o    = sel_we;
                mem_addr_o  = sel_addr;
                mem_wdata_o = sel_wdata;
                mem_be_o    = sel_be;
                if (cur_owner) ls_gnt_o = mem_gnt_i;
                else           if_gnt_o = mem_gnt_i;
                if (mem_rvalid_i) spurious_d = 1'b1;
                if (mem_gnt_i) begin
                    cnt_d   = '0;
                    state_d = cur_owner ? ST_WAIT_LS : ST_WAIT_IF;
                end
            end
            ST_WAIT_IF, ST_WAIT_LS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cur_owner) begin
                    ls_rvalid_o = rsp_vld;
                    ls_rdata_o  = rsp_data;
                    ls_err_o    = timeout_hit;
                end else begin
                    if_rvalid_o = rsp_vld;
                    if_rdata_o  = rsp_data;
                    if_err_o    = timeout_hit;
                end
                if (rsp_vld) begin
                    arb_en  = 1'b1;
                    state_d = req_state(gnt_vld, gnt_owner);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            spurious_q <= spurious_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (round-robin with timeout 4, LS
// priority without timeout) share directed stimulus and a transaction model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] ls_addr = 32'h0, ls_wdata = 32'h0;
    logic [3:0]  ls_be = 4'h0;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        o_if_gnt[2], o_if_rvalid[2], o_if_err[2];
    logic        o_ls_gnt[2], o_ls_rvalid[2], o_ls_err[2];
    logic        o_mem_req[2], o_mem_we[2], o_own[2], o_spur[2];
    logic [31:0] o_if_rdata[2], o_ls_rdata[2], o_mem_addr[2], o_mem_wdata[2];
    logic [3:0]  o_mem_be[2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.PRIO_LS(1'b0), .TIMEOUT_CYCLES(4), .CNT_W(8)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(o_if_gnt[0]),
        .if_rvalid_o(o_if_rvalid[0]), .if_rdata_o(o_if_rdata[0]), .if_err_o(o_if_err[0]),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_be_i(ls_be), .ls_gnt_o(o_ls_gnt[0]), .ls_rvalid_o(o_ls_rvalid[0]),
        .ls_rdata_o(o_ls_rdata[0]), .ls_err_o(o_ls_err[0]),
        .mem_req_o(o_mem_req[0]), .mem_we_o(o_mem_we[0]), .mem_addr_o(o_mem_addr[0]),
        .mem_wdata_o(o_mem_wdata[0]), .mem_be_o(o_mem_be[0]), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .owner_sel_o(o_own[0]), .spurious_o(o_spur[0])
    );

    mem_port_arbiter #(.PRIO_LS(1'b1), .TIMEOUT_CYCLES(0), .CNT_W(8)) u_pr (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(o_if_gnt[1]),
        .if_rvalid_o(o_if_rvalid[1]), .if_rdata_o(o_if_rdata[1]), .if_err_o(o_if_err[1]),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_be_i(ls_be), .ls_gnt_o(o_ls_gnt[1]), .ls_rvalid_o(o_ls_rvalid[1]),
        .ls_rdata_o(o_ls_rdata[1]), .ls_err_o(o_ls_err[1]),
        .mem_req_o(o_mem_req[1]), .mem_we_o(o_mem_we[1]), .mem_addr_o(o_mem_addr[1]),
        .mem_wdata_o(o_mem_wdata[1]), .mem_be_o(o_mem_be[1]), .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .owner_sel_o(o_own[1]), .spurious_o(o_spur[1])
    );

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h want=%h t=%0t", name, d, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction per instance.
    int  to_p[2]   = '{4, 0};
    bit  prio_p[2] = '{1'b0, 1'b1};
    bit  m_busy[2], m_gntd[2], m_own[2], m_last[2], m_spur[2];
    int  m_wait[2];

    function automatic bit pick(input bit ifr, input bit lsr, input bit last, input bit prio);
        if (ifr && lsr) return prio ? 1'b1 : !last;
        return lsr;
    endfunction

    task automatic model_cycle(input int d);
        bit pend, wt, tmo, rv, done;
        logic [31:0] rd;
        if (!rst_n) begin
            m_busy[d] = 0; m_gntd[d] = 0; m_own[d] = 0; m_last[d] = 0;
            m_spur[d] = 0; m_wait[d] = 0;
        end
        pend = m_busy[d] && !m_gntd[d];
        wt   = m_busy[d] && m_gntd[d];
        tmo  = wt && (to_p[d] != 0) && (m_wait[d] == to_p[d] - 1) && !mem_rvalid;
        rv   = wt && (mem_rvalid || tmo);
        rd   = wt ? (tmo ? 32'h0 : mem_rdata) : 32'h0;
        chk("m_mem_req",   d, o_mem_req[d],   pend);
        chk("m_owner_sel", d, o_own[d],       m_busy[d] && m_own[d]);
        chk("m_mem_we",    d, o_mem_we[d],    pend && m_own[d] && ls_we);
        chk("m_mem_addr",  d, o_mem_addr[d],  !pend ? 32'h0 : (m_own[d] ? ls_addr : if_addr));
        chk("m_mem_wdata", d, o_mem_wdata[d], (pend && m_own[d]) ? ls_wdata : 32'h0);
        chk("m_mem_be",    d, o_mem_be[d],    !pend ? 4'h0 : (m_own[d] ? ls_be : 4'hF));
        chk("m_if_gnt",    d, o_if_gnt[d],    pend && !m_own[d] && mem_gnt);
        chk("m_ls_gnt",    d, o_ls_gnt[d],    pend && m_own[d] && mem_gnt);
        chk("m_if_rvalid", d, o_if_rvalid[d], rv && !m_own[d]);
        chk("m_ls_rvalid", d, o_ls_rvalid[d], rv && m_own[d]);
        chk("m_if_err",    d, o_if_err[d],    tmo && !m_own[d]);
        chk("m_ls_err",    d, o_ls_err[d],    tmo && m_own[d]);
        chk("m_if_rdata",  d, o_if_rdata[d],  m_own[d] ? 32'h0 : rd);
        chk("m_ls_rdata",  d, o_ls_rdata[d],  m_own[d] ? rd : 32'h0);
        chk("m_spurious",  d, o_spur[d],      m_spur[d]);
        if (!rst_n) return;
        if ((!m_busy[d] || pend) && mem_rvalid) m_spur[d] = 1;
        done = !m_busy[d] || rv;
        if (pend && mem_gnt) begin
            m_gntd[d] = 1; m_wait[d] = 0;
        end else if (wt && !done) begin
            m_wait[d]++;
        end
        if (done) begin
            if (if_req || ls_req) begin
                m_own[d]  = pick(if_req, ls_req, m_last[d], prio_p[d]);
                m_last[d] = m_own[d];
                m_busy[d] = 1; m_gntd[d] = 0;
            end else begin
                m_busy[d] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) model_cycle(d);
    end

    // Requesters must hold req until granted.
    logic pend_if_q[2], pend_ls_q[2];
    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                pend_if_q[d] <= 1'b0;
                pend_ls_q[d] <= 1'b0;
            end else begin
                assert (!(pend_if_q[d] && !if_req)) else $error("FAIL if_req_drop dut%0d", d);
                assert (!(pend_ls_q[d] && !ls_req)) else $error("FAIL ls_req_drop dut%0d", d);
                pend_if_q[d] <= if_req && !o_if_gnt[d];
                pend_ls_q[d] <= ls_req && !o_ls_gnt[d];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_mem_req", d, o_mem_req[d], 1'b0);
            chk("rst_owner",   d, o_own[d],     1'b0);
            chk("rst_spur",    d, o_spur[d],    1'b0);
        end

        // Single IF read
        tick(); if_req = 1'b1; if_addr = 32'h0000_0100; #1;
        chk("if_c0_req", 0, o_mem_req[0], 1'b0);
        tick(); mem_gnt = 1'b1; #1;
        for (int d = 0; d < 2; d++) begin
            chk("if_c1_req",  d, o_mem_req[d],  1'b1);
            chk("if_c1_addr", d, o_mem_addr[d], 32'h100);
            chk("if_c1_we",   d, o_mem_we[d],   1'b0);
            chk("if_c1_be",   d, o_mem_be[d],   4'hF);
            chk("if_c1_gnt",  d, o_if_gnt[d],   1'b1);
        end
        tick(); if_req = 1'b0; mem_gnt = 1'b0; #1;
        chk("if_c2_rvalid", 0, o_if_rvalid[0], 1'b0);
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        for (int d = 0; d < 2; d++) begin
            chk("if_c3_rvalid",  d, o_if_rvalid[d], 1'b1);
            chk("if_c3_rdata",   d, o_if_rdata[d],  32'hDEAD_BEEF);
            chk("if_c3_err",     d, o_if_err[d],    1'b0);
            chk("if_c3_lsvalid", d, o_ls_rvalid[d], 1'b0);
            chk("if_c3_lsrdata", d, o_ls_rdata[d],  32'h0);
        end
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // LS write with grant held off for three cycles
        tick(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h2000;
        ls_wdata = 32'h1234_5678; ls_be = 4'b0011;
        for (int c = 1; c <= 3; c++) begin
            tick(); #1;
            for (int d = 0; d < 2; d++) begin
                chk("ls_hold_req",   d, o_mem_req[d],   1'b1);
                chk("ls_hold_we",    d, o_mem_we[d],    1'b1);
                chk("ls_hold_addr",  d, o_mem_addr[d],  32'h2000);
                chk("ls_hold_wdata", d, o_mem_wdata[d], 32'h1234_5678);
                chk("ls_hold_be",    d, o_mem_be[d],    4'b0011);
                chk("ls_hold_gnt",   d, o_ls_gnt[d],    1'b0);
                chk("ls_hold_own",   d, o_own[d],       1'b1);
            end
        end
        tick(); mem_gnt = 1'b1; #1;
        chk("ls_gnt", 0, o_ls_gnt[0], 1'b1);
        tick(); ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;
        ls_be = 4'h0; mem_gnt = 1'b0; #1;
        chk("ls_wait_req", 0, o_mem_req[0], 1'b0);
        tick(); mem_rvalid = 1'b1; #1;
        chk("ls_rvalid", 0, o_ls_rvalid[0], 1'b1);
        chk("ls_err",    0, o_ls_err[0],    1'b0);
        tick(); mem_rvalid = 1'b0;

        // Tie: both held, memory grants at once and responds the next cycle
        do_reset();
        tick(); if_req = 1'b1; if_addr = 32'h400; ls_req = 1'b1; ls_addr = 32'h800;
        ls_be = 4'hF; mem_gnt = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            mem_rvalid = (c % 2 == 0);
            if (c == 10) ls_req = 1'b0;
            if (c == 12) if_req = 1'b0;
            #1;
            if (c % 2 == 1) begin
                k = (c + 1) / 2;
                chk("tie_rr_own",    0, o_own[0],    (k % 2 == 1) ? 1'b1 : 1'b0);
                chk("tie_prio_own",  1, o_own[1],    (k <= 5) ? 1'b1 : 1'b0);
                chk("tie_prio_ifg",  1, o_if_gnt[1], (k == 6) ? 1'b1 : 1'b0);
            end
        end
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b0; #1;
        for (int d = 0; d < 2; d++) chk("tie_idle", d, o_mem_req[d], 1'b0);

        // Timeout after four WAIT cycles on the round-robin instance
        tick(); ls_req = 1'b1; ls_addr = 32'h3000;
        tick(); mem_gnt = 1'b1; #1;
        chk("to_gnt", 0, o_ls_gnt[0], 1'b1);
        tick(); ls_req = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'hAAAA_5555;
        tick();
        tick(); #1;
        chk("to_c4_rvalid", 0, o_ls_rvalid[0], 1'b0);
        tick(); #1;
        chk("to_rvalid",    0, o_ls_rvalid[0], 1'b1);
        chk("to_err",       0, o_ls_err[0],    1'b1);
        chk("to_rdata",     0, o_ls_rdata[0],  32'h0);
        chk("to_nto_valid", 1, o_ls_rvalid[1], 1'b0);
        tick(); #1;
        chk("to_after", 0, o_ls_rvalid[0], 1'b0);
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'h55; #1;
        chk("late_nto_rvalid", 1, o_ls_rvalid[1], 1'b1);
        chk("late_nto_rdata",  1, o_ls_rdata[1],  32'h55);
        chk("late_to_rvalid",  0, o_ls_rvalid[0], 1'b0);
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
        chk("late_spur", 0, o_spur[0], 1'b1);
        chk("late_nospur", 1, o_spur[1], 1'b0);

        // Reset during WAIT_IF, then a normal LS transaction
        tick(); if_req = 1'b1; if_addr = 32'h500;
        tick(); mem_gnt = 1'b1;
        tick(); if_req = 1'b0; mem_gnt = 1'b0;
        tick(); mem_rdata = 32'h77; #1;
        chk("rw_rdata", 0, o_if_rdata[0], 32'h77);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rw_if_rdata", d, o_if_rdata[d], 32'h0);
            chk("rw_mem_req",  d, o_mem_req[d],  1'b0);
            chk("rw_spur",     d, o_spur[d],     1'b0);
            chk("rw_owner",    d, o_own[d],      1'b0);
        end
        tick(); mem_rdata = 32'h0;
        tick(); rst_n = 1'b1;
        tick(); ls_req = 1'b1; ls_addr = 32'h600; ls_be = 4'hF;
        tick(); mem_gnt = 1'b1; #1;
        for (int d = 0; d < 2; d++) begin
            chk("rr_ls_gnt",  d, o_ls_gnt[d],   1'b1);
            chk("rr_ls_addr", d, o_mem_addr[d], 32'h600);
            chk("rr_owner",   d, o_own[d],      1'b1);
            chk("rr_if_gnt",  d, o_if_gnt[d],   1'b0);
        end
        tick(); ls_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99; #1;
        chk("rr_ls_rvalid", 0, o_ls_rvalid[0], 1'b1);
        chk("rr_ls_rdata",  0, o_ls_rdata[0],  32'h99);
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'h0;
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
